// File: rtl/seq_divider_nbym.sv
// seq_divider_nbym: sequential restoring divider, N-bit dividend by M-bit divisor.
// Produces one quotient bit per clock and returns quotient and remainder with a
// start/done handshake. Division by zero completes at once with Q all-ones,
// R zero and div_by_zero set.
//
// Optional feature (macro SEQ_DIVIDER_EARLY_EXIT_EN): when the dividend is
// smaller than the divisor, the result (Q=0, R=A) is returned without the
// N-cycle RUN phase. With the macro undefined, those operands take the full
// RUN path and give the same Q/R.

module seq_divider_nbym #(
    parameter int unsigned N = 8,  // dividend / quotient width, N >= M
    parameter int unsigned M = 4   // divisor / remainder width
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [M-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [M-1:0] R,
    output logic         div_by_zero
);

    localparam int unsigned CntW = $clog2(N + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;

    // The dividend shift register also collects the quotient: one dividend bit
    // leaves at the MSB while one quotient bit enters at the LSB.
    logic [N-1:0]    dvd_q, dvd_d;
    logic [M-1:0]    dvs_q, dvs_d;
    // Partial remainder is one bit wider than the divisor so the shifted value
    // (up to 2*B-1) never overflows before the compare/subtract.
    logic [M:0]      p_q, p_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    q_q, q_d;
    logic [M-1:0]    r_q, r_d;
    logic            dbz_q, dbz_d;

    // Datapath for one restoring step.
    logic [M:0]      p_shift;
    logic [M:0]      dvs_ext;
    logic            q_bit;
    logic [M:0]      p_step;
    logic [N-1:0]    dvd_step;
    logic            cnt_last;

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    logic [N-1:0]    b_wide;
    logic            a_lt_b;
`endif

    // One restoring-division step: shift, trial subtract, keep or restore.
    always_comb begin
        p_shift  = {p_q[M-1:0], dvd_q[N-1]};
        dvs_ext  = {1'b0, dvs_q};
        q_bit    = (p_shift >= dvs_ext);
        p_step   = q_bit ? (p_shift - dvs_ext) : p_shift;
        dvd_step = {dvd_q[N-2:0], q_bit};
        cnt_last = (cnt_q == CntW'(1));
    end

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    // Zero-extended compare of the live operands for the early-exit shortcut.
    always_comb begin
        b_wide        = '0;
        b_wide[M-1:0] = B;
        a_lt_b        = (A < b_wide);
    end
`endif

    // Next-state and result logic for the IDLE / RUN / DONE controller.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (B == '0) begin
                        state_d = StDone;
                        q_d     = '1;
                        r_d     = '0;
                        dbz_d   = 1'b1;
                    end
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
                    else if (a_lt_b) begin
                        state_d = StDone;
                        q_d     = '0;
                        r_d     = A[M-1:0];
                        dbz_d   = 1'b0;
                    end
`endif
                    else begin
                        state_d = StRun;
                        dvd_d   = A;
                        dvs_d   = B;
                        p_d     = '0;
                        cnt_d   = CntW'(N);
                        dbz_d   = 1'b0;
                    end
                end
            end

            StRun: begin
                dvd_d = dvd_step;
                p_d   = p_step;
                cnt_d = cnt_q - CntW'(1);
                // Final step: publish the result on the same edge that enters DONE.
                if (cnt_last) begin
                    state_d = StDone;
                    q_d     = dvd_step;
                    r_d     = p_step[M-1:0];
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            dvd_q   <= '0;
            dvs_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign Q           = q_q;
    assign R           = r_q;
    assign div_by_zero = dbz_q;

endmodule
